// File: rtl/serial_to_parallel_register_pkg.sv
// Shared types and constants for the serial-to-parallel capture block.
package serial_to_parallel_register_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_to_parallel_register_if.sv
// Handshake and data bundle between a serial producer/word consumer and the capture block.
interface serial_to_parallel_register_if
    import serial_to_parallel_register_pkg::*;
#(
    parameter int unsigned N = DEFAULT_WIDTH
) ();

    logic         start;
    logic         enable;
    logic         serial_in;
    logic         abort;
    logic         ack;
    logic [N-1:0] q;
    logic         valid;
    logic         busy;

    modport master (
        output start, enable, serial_in, abort, ack,
        input  q, valid, busy
    );

    modport slave (
        input  start, enable, serial_in, abort, ack,
        output q, valid, busy
    );

endinterface

// File: rtl/serial_to_parallel_register_bit_counter.sv
// Modulo-N bit counter with synchronous clear, count enable and terminal-count flag.
module bit_counter #(
    parameter int unsigned N = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tc_c
);

    localparam int unsigned CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= (r_count == LAST) ? '0 : r_count + CW'(1);
        end
    end

    assign o_tc_c = (r_count == LAST);

endmodule

// File: rtl/serial_to_parallel_register.sv
// Captures N serial bits (MSB first) into a word and holds it until acknowledged.
module serial_to_parallel_register
    import serial_to_parallel_register_pkg::*;
#(
    parameter int unsigned N = DEFAULT_WIDTH
) (
    input  logic                          clock,
    input  logic                          reset,
    serial_to_parallel_register_if.slave  bus
);

    state_t       r_state;
    state_t       w_next;
    logic [N-2:0] r_shift;
    logic [N-1:0] r_q;
    logic         r_valid;
    logic         r_busy;

    logic         w_tc;
    logic         w_begin;
    logic         w_take;
    logic         w_done;
    logic         w_clear;
    logic         w_busy_d;
    logic         w_valid_d;
    logic [N-1:0] w_shift_next;

    // Only N-1 bits need storing: the Nth bit goes straight into q.
    assign w_shift_next = {r_shift, bus.serial_in};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) w_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (bus.abort)                w_next = ST_IDLE;
                else if (bus.enable && w_tc)  w_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (bus.ack) w_next = bus.start ? ST_SHIFT : ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy_d  = 1'b0;
        w_valid_d = 1'b0;
        w_begin   = 1'b0;
        w_take    = 1'b0;
        w_done    = 1'b0;
        w_clear   = 1'b0;
        w_busy_d  = (w_next == ST_SHIFT);
        w_valid_d = (w_next == ST_HOLD);
        w_begin   = (w_next == ST_SHIFT) && (r_state != ST_SHIFT);
        w_take    = (r_state == ST_SHIFT) && bus.enable && !bus.abort;
        w_done    = w_take && w_tc;
        w_clear   = w_begin || ((r_state == ST_SHIFT) && bus.abort);
    end

    bit_counter #(
        .N (N)
    ) u_bit_counter (
        .clock    (clock),
        .reset    (reset),
        .i_clear  (w_clear),
        .i_enable (w_take),
        .o_tc_c   (w_tc)
    );

    // q is written only when the last bit lands, so partial words never show.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_shift <= '0;
            r_q     <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            if (w_begin) begin
                r_shift <= '0;
            end else if (w_take) begin
                r_shift <= w_shift_next[N-2:0];
            end
            if (w_done) begin
                r_q <= w_shift_next;
            end
            r_busy  <= w_busy_d;
            r_valid <= w_valid_d;
        end
    end

    assign bus.q     = r_q;
    assign bus.valid = r_valid;
    assign bus.busy  = r_busy;

endmodule

// File: tb/tb_serial_to_parallel_register.sv
// Randomized scoreboard bench for serial_to_parallel_register at N=8, N=2 and N=16.
module tb_serial_to_parallel_register;

    typedef struct {
        int          d;
        logic [15:0] w;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    bit r_start [3];
    bit r_en    [3];
    bit r_si    [3];
    bit r_ab    [3];
    bit r_ack   [3];

    logic [15:0] w_q     [3];
    logic        w_valid [3];
    logic        w_busy  [3];

    exp_t        sb [$];
    logic [15:0] last_word [3];
    int          widths [3] = '{8, 2, 16};
    bit          g_bits [16];
    bit          prev_v [3];
    int          n_checks = 0;
    int          n_errors = 0;

    serial_to_parallel_register_if #(.N(8))  if8  ();
    serial_to_parallel_register_if #(.N(2))  if2  ();
    serial_to_parallel_register_if #(.N(16)) if16 ();

    assign if8.start      = r_start[0];
    assign if8.enable     = r_en[0];
    assign if8.serial_in  = r_si[0];
    assign if8.abort      = r_ab[0];
    assign if8.ack        = r_ack[0];
    assign if2.start      = r_start[1];
    assign if2.enable     = r_en[1];
    assign if2.serial_in  = r_si[1];
    assign if2.abort      = r_ab[1];
    assign if2.ack        = r_ack[1];
    assign if16.start     = r_start[2];
    assign if16.enable    = r_en[2];
    assign if16.serial_in = r_si[2];
    assign if16.abort     = r_ab[2];
    assign if16.ack       = r_ack[2];

    assign w_q[0]     = 16'(if8.q);
    assign w_q[1]     = 16'(if2.q);
    assign w_q[2]     = if16.q;
    assign w_valid[0] = if8.valid;
    assign w_valid[1] = if2.valid;
    assign w_valid[2] = if16.valid;
    assign w_busy[0]  = if8.busy;
    assign w_busy[1]  = if2.busy;
    assign w_busy[2]  = if16.busy;

    serial_to_parallel_register #(.N(8))  dut8  (.clock(clk), .reset(rst), .bus(if8));
    serial_to_parallel_register #(.N(2))  dut2  (.clock(clk), .reset(rst), .bus(if2));
    serial_to_parallel_register #(.N(16)) dut16 (.clock(clk), .reset(rst), .bus(if16));

    always #5 clk = ~clk;

    // Monitor: every new valid word is matched against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            if (!rst && w_valid[d] && !prev_v[d]) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_errors++;
                    $display("FAIL sb_unexpected_word dut%0d: got q=%h, none expected", d, w_q[d]);
                end else begin
                    e = sb.pop_front();
                    if (e.d != d || e.w !== w_q[d]) begin
                        n_errors++;
                        $display("FAIL sb_word dut%0d: got q=%h, want dut%0d q=%h", d, w_q[d], e.d, e.w);
                    end
                end
            end
            prev_v[d] = w_valid[d];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic clear_inputs(input int d);
        r_start[d] = 1'b0;
        r_en[d]    = 1'b0;
        r_si[d]    = 1'b0;
        r_ab[d]    = 1'b0;
        r_ack[d]   = 1'b0;
    endtask

    task automatic load_word(input int n, input logic [15:0] w);
        for (int i = 0; i < n; i++) g_bits[i] = w[n-1-i];
    endtask

    task automatic load_random(input int n);
        for (int i = 0; i < n; i++) g_bits[i] = 1'($urandom);
    endtask

    // Sends g_bits MSB first; abort_at >= 0 aborts on that bit's edge.
    task automatic capture(input int d, input bit need_start, input int min_gap, input int max_gap,
                           input int abort_at, input bit noise);
        int          n;
        int          gap;
        logic [15:0] exp;
        exp_t        e;
        n   = widths[d];
        exp = 16'd0;
        for (int i = 0; i < n; i++) exp = 16'(exp * 2 + 16'(g_bits[i]));
        if (abort_at < 0) begin
            e.d = d;
            e.w = exp;
            sb.push_back(e);
        end
        if (need_start) begin
            r_start[d] = 1'b1;
            r_ack[d]   = noise ? 1'($urandom) : 1'b0;
            tick();
            clear_inputs(d);
            check("start_busy", 16'(w_busy[d]), 16'd1);
        end
        for (int i = 0; i < n; i++) begin
            gap = min_gap + int'($urandom_range(max_gap - min_gap, 0));
            repeat (gap) begin
                r_en[d] = 1'b0;
                r_si[d] = 1'($urandom);
                if (noise) begin
                    r_start[d] = 1'($urandom);
                    r_ack[d]   = 1'($urandom);
                end
                tick();
                clear_inputs(d);
                check("gap_q_stable", w_q[d], last_word[d]);
            end
            r_en[d] = 1'b1;
            r_si[d] = g_bits[i];
            r_ab[d] = (i == abort_at);
            if (noise) begin
                r_start[d] = 1'($urandom);
                r_ack[d]   = 1'($urandom);
            end
            tick();
            clear_inputs(d);
            if (i == abort_at) begin
                check("abort_busy", 16'(w_busy[d]), 16'd0);
                check("abort_valid", 16'(w_valid[d]), 16'd0);
                check("abort_q_kept", w_q[d], last_word[d]);
                return;
            end
            if (i < n - 1) begin
                check("partial_q_stable", w_q[d], last_word[d]);
                check("partial_busy", 16'(w_busy[d]), 16'd1);
            end
        end
        check("done_valid", 16'(w_valid[d]), 16'd1);
        check("done_busy", 16'(w_busy[d]), 16'd0);
        last_word[d] = exp;
    endtask

    task automatic hold(input int d, input int cycles);
        repeat (cycles) begin
            r_en[d]    = 1'($urandom);
            r_si[d]    = 1'($urandom);
            r_start[d] = 1'($urandom);
            r_ab[d]    = 1'($urandom);
            r_ack[d]   = 1'b0;
            tick();
            clear_inputs(d);
            check("hold_valid", 16'(w_valid[d]), 16'd1);
            check("hold_busy", 16'(w_busy[d]), 16'd0);
            check("hold_q", w_q[d], last_word[d]);
        end
    endtask

    task automatic release_hold(input int d, input bit with_start);
        r_ack[d]   = 1'b1;
        r_start[d] = with_start;
        tick();
        clear_inputs(d);
        check("release_valid", 16'(w_valid[d]), 16'd0);
        check("release_busy", 16'(w_busy[d]), 16'(with_start));
    endtask

    initial begin
        bit started;
        bit ws;
        int ab;
        for (int d = 0; d < 3; d++) begin
            clear_inputs(d);
            last_word[d] = 16'd0;
        end
        #1;
        for (int d = 0; d < 3; d++) begin
            check("reset_q", w_q[d], 16'd0);
            check("reset_valid", 16'(w_valid[d]), 16'd0);
            check("reset_busy", 16'(w_busy[d]), 16'd0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tick();

        // Reference word 1,0,1,1,0,0,1,0 back to back, then with 3-cycle gaps.
        load_word(8, 16'h00B2);
        capture(0, 1'b1, 0, 0, -1, 1'b0);
        release_hold(0, 1'b0);
        capture(0, 1'b1, 3, 3, -1, 1'b0);

        // Long hold with noise, then ack+start straight into a new capture.
        hold(0, 10);
        release_hold(0, 1'b1);
        load_random(8);
        capture(0, 1'b0, 0, 2, -1, 1'b1);
        hold(0, 2);
        release_hold(0, 1'b0);

        // Abort on the final bit, idle noise, then a clean capture.
        load_random(8);
        capture(0, 1'b1, 0, 1, 7, 1'b1);
        repeat (4) begin
            r_en[0]  = 1'b1;
            r_si[0]  = 1'($urandom);
            r_ab[0]  = 1'($urandom);
            r_ack[0] = 1'($urandom);
            tick();
            clear_inputs(0);
            check("idle_valid", 16'(w_valid[0]), 16'd0);
            check("idle_busy", 16'(w_busy[0]), 16'd0);
            check("idle_q", w_q[0], last_word[0]);
        end
        load_random(8);
        capture(0, 1'b1, 0, 1, -1, 1'b0);
        release_hold(0, 1'b0);
        load_random(8);
        capture(0, 1'b1, 0, 1, 3, 1'b0);

        // Asynchronous reset between edges after five bits.
        load_random(8);
        r_start[0] = 1'b1;
        tick();
        clear_inputs(0);
        for (int i = 0; i < 5; i++) begin
            r_en[0] = 1'b1;
            r_si[0] = g_bits[i];
            tick();
        end
        clear_inputs(0);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_q", w_q[0], 16'd0);
        check("async_reset_valid", 16'(w_valid[0]), 16'd0);
        check("async_reset_busy", 16'(w_busy[0]), 16'd0);
        for (int d = 0; d < 3; d++) last_word[d] = 16'd0;
        #2;
        rst = 1'b0;
        tick();
        load_word(8, 16'h005A);
        capture(0, 1'b1, 0, 0, -1, 1'b0);
        release_hold(0, 1'b0);

        // Narrowest and wide instances.
        load_word(2, 16'h0002);
        capture(1, 1'b1, 0, 0, -1, 1'b0);
        release_hold(1, 1'b0);
        repeat (4) begin
            load_random(2);
            capture(1, 1'b1, 0, 2, -1, 1'b1);
            hold(1, 1);
            release_hold(1, 1'b0);
        end
        load_word(16, 16'hC3A5);
        capture(2, 1'b1, 0, 0, -1, 1'b0);
        release_hold(2, 1'b1);
        load_random(16);
        capture(2, 1'b0, 0, 2, -1, 1'b1);
        release_hold(2, 1'b0);

        // Random traffic on the 8-bit instance with occasional aborts.
        started = 1'b0;
        for (int it = 0; it < 20; it++) begin
            load_random(8);
            ab = ($urandom_range(4, 0) == 0) ? int'($urandom_range(7, 0)) : -1;
            capture(0, !started, 0, 2, ab, 1'b1);
            if (ab >= 0) begin
                started = 1'b0;
            end else begin
                hold(0, int'($urandom_range(3, 0)));
                ws = (it < 19) ? 1'($urandom) : 1'b0;
                release_hold(0, ws);
                started = ws;
            end
        end

        repeat (2) tick();
        check("sb_empty", 16'(sb.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
